memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Consumer end of the execute-to-memory pipeline latch.
- Takes the latched address (alu_out), store data (rdat2) and memory-control fields, and drives a single-outstanding request/ready data-bus handshake.
- Holds the pipeline with mem_stall until the bus responds.
- Returns byte/halfword/word load results, sign- or zero-extended, to the memory-to-writeback latch.

Parameters:
- TIMEOUT_CYCLES, 64, ready-wait limit before bus error; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge
- nrst  in  1  asynchronous active-low reset
- ex_valid  in  1  latch holds a live instruction (not flushed/bubble)
- flush  in  1  squash current instruction
- dread  in  1  load request
- dwrite  in  2  store size: 0 none, 1 byte, 2 halfword, 3 word
- reg_wr_mem  in  2  load size: 0 byte, 1 halfword, 2 word
- reg_wr_mem_signed  in  1  1 sign-extend load, 0 zero-extend
- alu_out  in  32  effective byte address
- rdat2  in  32  store data, right-aligned
- dmem_req  out  1  bus request
- dmem_wen  out  1  1 write, 0 read
- dmem_addr  out  32  word-aligned address, i.e. {alu_out[31:2],2'b00}
- dmem_strb  out  4  byte-lane write strobes
- dmem_wdata  out  32  lane-aligned write data
- dmem_rdata  in  32  read data, valid with dmem_ready
- dmem_ready  in  1  bus completes the transfer this cycle
- mem_stall  out  1  hold upstream latches
- load_data  out  32  formatted load result
- mem_done  out  1  one-cycle pulse: access retired
- misaligned  out  1  one-cycle pulse: misaligned access trapped
- bus_error  out  1  one-cycle pulse: timeout (feature only)

Behaviour:
- Reset (nrst=0, async): state IDLE; dmem_req, dmem_wen, mem_done, misaligned, bus_error = 0; dmem_addr, dmem_strb, dmem_wdata, load_data = 0.
- Access condition: access = ex_valid & ~flush & (dread | dwrite!=0). dread and dwrite!=0 both set is illegal; dread takes priority.
- Misalignment:
  - Halfword with addr[0]=1, or word with addr[1:0]!=0.
  - In IDLE: no request; misaligned pulses the next cycle; mem_stall stays 0.
- FSM states IDLE, BUSY, DONE.
  - IDLE to BUSY on an aligned access. The bus outputs are registered on that edge, so dmem_req rises one cycle after entry; dmem_addr, dmem_wen, dmem_strb and dmem_wdata are captured with it.
  - BUSY: dmem_req held high and all bus outputs stable until dmem_ready. On ready: dmem_req drops next edge; load_data registered; go to DONE.
  - dmem_ready already high on the first BUSY cycle completes immediately, giving a minimum latency of 2 cycles from latch entry to mem_done.
  - DONE: mem_done=1 for exactly one cycle, then IDLE.
- mem_stall = (state==IDLE & aligned access) | state==BUSY. Combinational. It is 0 in DONE, so the latch advances on the DONE edge.
- Store lane mapping (off = alu_out[1:0]):
  - byte: strb = 1<<off, wdata = {4{rdat2[7:0]}}
  - halfword: strb = 4'b0011<<off, wdata = {2{rdat2[15:0]}}
  - word: strb = 4'hF, wdata = rdat2
- Loads: dmem_strb = 0. Selected lane shifted down by 8*off, then sign- or zero-extended to 32 bits.
- Flush during BUSY: the transaction is not aborted. It completes on dmem_ready, but mem_done is suppressed and load_data is not updated. A flush that is set is remembered until completion.
- dmem_ready in IDLE/DONE: ignored.
- Reset mid-BUSY: immediate return to IDLE, dmem_req=0. The bus must tolerate the dropped request.
- Non-memory instructions: pass through with mem_stall=0 and no pulses.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter, cleared on BUSY entry, increments each BUSY cycle without dmem_ready.
  - On reaching TIMEOUT_CYCLES: request dropped; bus_error pulses one cycle; state goes to DONE with mem_done suppressed.
  - A late dmem_ready is ignored.
- MEM_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; bus_error tied 0.

Test Plan:
- Word load, addr 0x100, rdata 0xDEADBEEF, ready after 3 cycles -> dmem_req high 3 cycles; mem_stall high through BUSY; load_data=0xDEADBEEF; one mem_done pulse.
- Signed byte load, addr 0x103, rdata 0x80112233 -> load_data=0xFFFFFF80. Unsigned version -> 0x00000080.
- Halfword store, addr 0x202, rdat2=0x0000ABCD -> strb=4'b1100, wdata=0xABCDABCD, wen=1, dmem_addr=0x200.
- Word load at addr 0x101 -> no dmem_req; misaligned pulses once; mem_stall=0.
- Flush asserted during BUSY, ready 2 cycles later -> transfer completes; no mem_done; load_data unchanged.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready never asserted -> dmem_req drops after 4 BUSY cycles; bus_error pulses once; mem_stall releases.

Source files
------------

// File: rtl/memory_stage.sv
// Memory stage: drives a single-outstanding req/ready data bus from the EX/MEM latch.
// Optional bus timeout is compiled in with `define MEM_TIMEOUT_EN.
module memory_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        ex_valid,
  input  logic        flush,
  input  logic        dread,
  input  logic [1:0]  dwrite,
  input  logic [1:0]  reg_wr_mem,
  input  logic        reg_wr_mem_signed,
  input  logic [31:0] alu_out,
  input  logic [31:0] rdat2,
  output logic        dmem_req,
  output logic        dmem_wen,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_strb,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        mem_stall,
  output logic [31:0] load_data,
  output logic        mem_done,
  output logic        misaligned,
  output logic        bus_error
);

  // Bus handshake: dmem_req rises with address/data/strobes and all of them
  // stay frozen until the cycle dmem_ready is seen high; req drops on that edge.
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_signed;
  logic        r_flushed;

  logic        w_access;
  logic [1:0]  w_off;
  logic [1:0]  w_size;
  logic        w_misal;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata;
  logic [31:0] w_lane;
  logic [31:0] w_load_fmt;

  assign w_access = ex_valid & ~flush & (dread | (dwrite != 2'd0));
  assign w_off    = alu_out[1:0];

  // Unified size code: 0 byte, 1 halfword, 2 word. Loads win over stores.
  always_comb begin
    w_size = 2'd2;
    if (dread) begin
      case (reg_wr_mem)
        2'd0:    w_size = 2'd0;
        2'd1:    w_size = 2'd1;
        default: w_size = 2'd2;
      endcase
    end else begin
      case (dwrite)
        2'd1:    w_size = 2'd0;
        2'd2:    w_size = 2'd1;
        default: w_size = 2'd2;
      endcase
    end
  end

  assign w_misal = ((w_size == 2'd1) & w_off[0]) | ((w_size == 2'd2) & (w_off != 2'd0));

  always_comb begin
    w_strb  = 4'hF;
    w_wdata = rdat2;
    case (dwrite)
      2'd1: begin
        w_strb  = 4'b0001 << w_off;
        w_wdata = {4{rdat2[7:0]}};
      end
      2'd2: begin
        w_strb  = 4'b0011 << w_off;
        w_wdata = {2{rdat2[15:0]}};
      end
      default: begin
        w_strb  = 4'hF;
        w_wdata = rdat2;
      end
    endcase
  end

  assign w_lane = dmem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load_fmt = w_lane;
    case (r_size)
      2'd0:    w_load_fmt = {{24{r_signed & w_lane[7]}},  w_lane[7:0]};
      2'd1:    w_load_fmt = {{16{r_signed & w_lane[15]}}, w_lane[15:0]};
      default: w_load_fmt = w_lane;
    endcase
  end

  assign mem_stall = ((r_state == S_IDLE) & w_access & ~w_misal) | (r_state == S_BUSY);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_tmo_cnt;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      dmem_req   <= 1'b0;
      dmem_wen   <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_strb  <= 4'd0;
      dmem_wdata <= 32'd0;
      load_data  <= 32'd0;
      mem_done   <= 1'b0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      r_off      <= 2'd0;
      r_size     <= 2'd0;
      r_signed   <= 1'b0;
      r_flushed  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_tmo_cnt  <= '0;
`endif
    end else begin
      mem_done   <= 1'b0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            if (w_misal) begin
              misaligned <= 1'b1;
            end else begin
              r_state    <= S_BUSY;
              dmem_req   <= 1'b1;
              dmem_wen   <= ~dread;
              dmem_addr  <= {alu_out[31:2], 2'b00};
              dmem_strb  <= dread ? 4'd0 : w_strb;
              dmem_wdata <= dread ? 32'd0 : w_wdata;
              r_off      <= w_off;
              r_size     <= w_size;
              r_signed   <= reg_wr_mem_signed;
              r_flushed  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
              r_tmo_cnt  <= '0;
`endif
            end
          end
        end
        S_BUSY: begin
          if (flush) r_flushed <= 1'b1;
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            r_state  <= S_DONE;
            // A squashed instruction still finishes on the bus but retires silently.
            if (!(r_flushed | flush)) begin
              mem_done <= 1'b1;
              if (!dmem_wen) load_data <= w_load_fmt;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_LAST) begin
            dmem_req  <= 1'b0;
            bus_error <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: loads, stores, misalignment, flush, reset, timeout.
module tb_memory_stage;

  logic        clk;
  logic        nrst;
  logic        ex_valid;
  logic        flush;
  logic        dread;
  logic [1:0]  dwrite;
  logic [1:0]  reg_wr_mem;
  logic        reg_wr_mem_signed;
  logic [31:0] alu_out;
  logic [31:0] rdat2;
  logic        dmem_req;
  logic        dmem_wen;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_strb;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        mem_stall;
  logic [31:0] load_data;
  logic        mem_done;
  logic        misaligned;
  logic        bus_error;

  int total = 0;
  int bad   = 0;

  memory_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .nrst(nrst), .ex_valid(ex_valid), .flush(flush),
    .dread(dread), .dwrite(dwrite), .reg_wr_mem(reg_wr_mem),
    .reg_wr_mem_signed(reg_wr_mem_signed), .alu_out(alu_out), .rdat2(rdat2),
    .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .mem_stall(mem_stall), .load_data(load_data),
    .mem_done(mem_done), .misaligned(misaligned), .bus_error(bus_error)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to the next falling edge; outputs are stable there
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; flush = 1'b0; dread = 1'b0; dwrite = 2'd0;
    reg_wr_mem = 2'd0; reg_wr_mem_signed = 1'b0; alu_out = 32'd0;
    rdat2 = 32'd0; dmem_rdata = 32'd0; dmem_ready = 1'b0;
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn);
    ex_valid = 1'b1; flush = 1'b0; dread = 1'b1; dwrite = 2'd0;
    reg_wr_mem = size; reg_wr_mem_signed = sgn; alu_out = addr;
  endtask

  task automatic drive_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
    ex_valid = 1'b1; flush = 1'b0; dread = 1'b0; dwrite = size;
    alu_out = addr; rdat2 = data;
  endtask

  // load issued, ready on first BUSY cycle, returns formatted result
  task automatic quick_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic sgn, input logic [31:0] rdata, input logic [31:0] exp);
    drive_load(addr, size, sgn);
    cyc();
    dmem_ready = 1'b1; dmem_rdata = rdata;
    cyc();
    chk({tag, "_done"}, {31'd0, mem_done}, 32'd1);
    chk({tag, "_data"}, load_data, exp);
    idle_inputs();
    cyc();
  endtask

  initial begin
    idle_inputs();
    nrst = 1'b0;
    cyc();
    cyc();
    chk("rst_req",   {31'd0, dmem_req}, 32'd0);
    chk("rst_wen",   {31'd0, dmem_wen}, 32'd0);
    chk("rst_addr",  dmem_addr, 32'd0);
    chk("rst_strb",  {28'd0, dmem_strb}, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_ldata", load_data, 32'd0);
    chk("rst_pulses", {29'd0, mem_done, misaligned, bus_error}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    nrst = 1'b1;
    cyc();

    // word load at 0x100, ready in the third BUSY cycle
    drive_load(32'h100, 2'd2, 1'b0);
    #1;
    chk("wl_stall_entry", {31'd0, mem_stall}, 32'd1);
    chk("wl_req_entry", {31'd0, dmem_req}, 32'd0);
    cyc();
    chk("wl_req_c1", {31'd0, dmem_req}, 32'd1);
    chk("wl_addr", dmem_addr, 32'h100);
    chk("wl_wen", {31'd0, dmem_wen}, 32'd0);
    chk("wl_strb", {28'd0, dmem_strb}, 32'd0);
    chk("wl_stall_c1", {31'd0, mem_stall}, 32'd1);
    cyc();
    chk("wl_req_c2", {31'd0, dmem_req}, 32'd1);
    chk("wl_done_c2", {31'd0, mem_done}, 32'd0);
    cyc();
    chk("wl_req_c3", {31'd0, dmem_req}, 32'd1);
    dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF;
    cyc();
    chk("wl_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("wl_done", {31'd0, mem_done}, 32'd1);
    chk("wl_data", load_data, 32'hDEADBEEF);
    chk("wl_stall_done", {31'd0, mem_stall}, 32'd0);
    idle_inputs();
    cyc();
    chk("wl_done_once", {31'd0, mem_done}, 32'd0);

    // byte / halfword load extension
    quick_load("lb_s",  32'h103, 2'd0, 1'b1, 32'h80112233, 32'hFFFFFF80);
    quick_load("lb_u",  32'h103, 2'd0, 1'b0, 32'h80112233, 32'h00000080);
    quick_load("lb_s0", 32'h100, 2'd0, 1'b1, 32'h80112233, 32'h00000033);
    quick_load("lh_s",  32'h102, 2'd1, 1'b1, 32'h80112233, 32'hFFFF8011);

    // halfword store at 0x202
    drive_store(32'h202, 2'd2, 32'h0000ABCD);
    cyc();
    chk("sh_req", {31'd0, dmem_req}, 32'd1);
    chk("sh_strb", {28'd0, dmem_strb}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
    chk("sh_wen", {31'd0, dmem_wen}, 32'd1);
    chk("sh_addr", dmem_addr, 32'h200);
    dmem_ready = 1'b1;
    cyc();
    chk("sh_done", {31'd0, mem_done}, 32'd1);
    chk("sh_ldata_kept", load_data, 32'hFFFF8011);
    idle_inputs();
    cyc();

    // byte store at 0x201
    drive_store(32'h201, 2'd1, 32'h12345678);
    cyc();
    chk("sb_strb", {28'd0, dmem_strb}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'h78787878);
    dmem_ready = 1'b1;
    cyc();
    idle_inputs();
    cyc();

    // misaligned word load at 0x101
    drive_load(32'h101, 2'd2, 1'b0);
    #1;
    chk("mis_stall", {31'd0, mem_stall}, 32'd0);
    cyc();
    chk("mis_pulse", {31'd0, misaligned}, 32'd1);
    chk("mis_req", {31'd0, dmem_req}, 32'd0);
    idle_inputs();
    cyc();
    chk("mis_once", {31'd0, misaligned}, 32'd0);

    // non-memory instruction with stray ready
    ex_valid = 1'b1; dmem_ready = 1'b1;
    #1;
    chk("nop_stall", {31'd0, mem_stall}, 32'd0);
    cyc();
    chk("nop_pulses", {29'd0, mem_done, misaligned, dmem_req}, 32'd0);
    idle_inputs();
    cyc();

    // flush during BUSY: transfer completes, no retire, data kept
    drive_load(32'h300, 2'd2, 1'b0);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("fl_req_held", {31'd0, dmem_req}, 32'd1);
    cyc();
    dmem_ready = 1'b1; dmem_rdata = 32'h11111111;
    cyc();
    chk("fl_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("fl_no_done", {31'd0, mem_done}, 32'd0);
    chk("fl_ldata", load_data, 32'hFFFF8011);
    chk("fl_stall", {31'd0, mem_stall}, 32'd0);
    idle_inputs();
    cyc();

    // asynchronous reset in the middle of BUSY
    drive_load(32'h400, 2'd2, 1'b0);
    cyc();
    chk("rb_req_busy", {31'd0, dmem_req}, 32'd1);
    nrst = 1'b0;
    #1;
    chk("rb_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("rb_ldata", load_data, 32'd0);
    idle_inputs();
    cyc();
    nrst = 1'b1;
    cyc();
    chk("rb_idle_stall", {31'd0, mem_stall}, 32'd0);

`ifdef MEM_TIMEOUT_EN
    // ready never arrives: four BUSY cycles then bus error
    drive_load(32'h500, 2'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("to_req_busy", {31'd0, dmem_req}, 32'd1);
    end
    cyc();
    chk("to_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("to_berr", {31'd0, bus_error}, 32'd1);
    chk("to_no_done", {31'd0, mem_done}, 32'd0);
    chk("to_stall", {31'd0, mem_stall}, 32'd0);
    idle_inputs();
    dmem_ready = 1'b1;
    cyc();
    chk("to_berr_once", {31'd0, bus_error}, 32'd0);
    chk("to_late_ready", {31'd0, mem_done}, 32'd0);
    idle_inputs();
    cyc();
`else
    chk("berr_tied", {31'd0, bus_error}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
